// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared definitions for the ALU sequencer: operation codes, control-word
//   bit positions, FSM state encoding and a one-hot helper for building
//   control words.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int CTRL_W = 10;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  // Control word bit positions (one bit per datapath action)
  localparam int C_LDX  = 0;  // A/Q <= X
  localparam int C_LDY  = 1;  // M <= Y
  localparam int C_INIT = 2;  // A <= 0, Q[-1] <= 0
  localparam int C_ALU  = 3;  // A <= A +/- M
  localparam int C_SUB  = 4;  // with C_ALU: subtract
  localparam int C_ASHR = 5;  // A:Q:Q[-1] arithmetic shift right
  localparam int C_SHL  = 6;  // A:Q shift left
  localparam int C_SETQ = 7;  // Q[0] <= ~a_msb
  localparam int C_OUTA = 8;  // drive A onto the bus
  localparam int C_OUTQ = 9;  // drive Q onto the bus

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_A    = 4'd1,
    S_LOAD_B    = 4'd2,
    S_DISPATCH  = 4'd3,
    S_EXEC_AS   = 4'd4,
    S_MUL_TEST  = 4'd5,
    S_MUL_SHIFT = 4'd6,
    S_DIV_SHIFT = 4'd7,
    S_DIV_OP    = 4'd8,
    S_DIV_Q     = 4'd9,
    S_DIV_FIX   = 4'd10,
    S_OUT_A     = 4'd11,
    S_OUT_Q     = 4'd12,
    S_DONE      = 4'd13,
    S_ERR       = 4'd14
  } state_e;

  // Control word with only bit idx set
  function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_iter_counter.sv
// ---------------------------------------------------------------------------
// alu_iter_counter
//   Iteration counter for the multi-cycle MUL/DIV loops. Cleared at the start
//   of each operation, advanced once per iteration, and flags the final
//   iteration. It holds at LAST instead of wrapping.
// Ports
//   clk    in   clock
//   rst_b  in   synchronous active-low reset
//   clr    in   clear count to 0 (wins over inc)
//   inc    in   advance count by one
//   cnt    out  current count
//   term   out  cnt == LAST
// ---------------------------------------------------------------------------
module alu_iter_counter #(
  parameter int CW   = 3,
  parameter int LAST = 7
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          term
);

  localparam logic [CW-1:0] LAST_V = CW'(LAST);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LAST_V)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == LAST_V);

endmodule

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Control sequencer for the shared A/Q/M ALU datapath. Runs add, subtract,
//   radix-2 Booth multiply and non-restoring divide on WIDTH-bit operands,
//   emitting a one-hot-per-action control word each cycle and reading back
//   datapath status flags. Divide by a zero divisor aborts with err.
// Ports
//   clk     in   clock
//   rst_b   in   synchronous active-low reset
//   start   in   operation request, sampled only in IDLE
//   op      in   2-bit opcode (ADD/SUB/MUL/DIV), latched with start
//   q0      in   datapath Q[0]
//   q_1     in   datapath Q[-1]
//   a_msb   in   datapath A sign bit
//   m_zero  in   datapath M == 0
//   c       out  10-bit control word
//   busy    out  high whenever not IDLE
//   finish  out  one-cycle end-of-operation pulse
//   err     out  divide-by-zero pulse, coincident with finish
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              q0,
  input  logic              q_1,
  input  logic              a_msb,
  input  logic              m_zero,
  output logic [CTRL_W-1:0] c,
  output logic              busy,
  output logic              finish,
  output logic              err
);

  localparam int CW = $clog2(WIDTH);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic          cnt_clr, cnt_inc, cnt_term;
  logic [CW-1:0] cnt_val;

  alu_iter_counter #(
    .CW   (CW),
    .LAST (WIDTH - 1)
  ) u_iter_counter (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt_val),
    .term  (cnt_term)
  );

  assign cnt_clr = (state_q == S_LOAD_A);
  assign cnt_inc = (state_q == S_MUL_SHIFT) || (state_q == S_DIV_Q);

  // Opcode is captured only when a request is accepted, so changes on op
  // while busy cannot disturb a running operation.
  assign op_d = ((state_q == S_IDLE) && start) ? op_e'(op) : op_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_LOAD_A;
      S_LOAD_A:    state_d = S_LOAD_B;
      S_LOAD_B:    state_d = S_DISPATCH;
      S_DISPATCH: begin
        case (op_q)
          OP_ADD, OP_SUB: state_d = S_EXEC_AS;
          OP_MUL:         state_d = S_MUL_TEST;
          default:        state_d = m_zero ? S_ERR : S_DIV_SHIFT;
        endcase
      end
      S_EXEC_AS:   state_d = S_OUT_A;
      S_MUL_TEST:  state_d = S_MUL_SHIFT;
      S_MUL_SHIFT: state_d = cnt_term ? S_OUT_A : S_MUL_TEST;
      S_DIV_SHIFT: state_d = S_DIV_OP;
      S_DIV_OP:    state_d = S_DIV_Q;
      S_DIV_Q:     state_d = cnt_term ? S_DIV_FIX : S_DIV_SHIFT;
      S_DIV_FIX:   state_d = S_OUT_A;
      S_OUT_A:     state_d = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? S_OUT_Q : S_DONE;
      S_OUT_Q:     state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      S_ERR:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    c      = '0;
    busy   = (state_q != S_IDLE);
    finish = 1'b0;
    err    = 1'b0;
    case (state_q)
      S_LOAD_A:    c = cbit(C_LDX);
      S_LOAD_B:    c = cbit(C_LDY);
      S_DISPATCH: begin
        // INIT only for the iterative ops; a zero divisor skips it entirely
        if (op_q == OP_MUL) c = cbit(C_INIT);
        else if ((op_q == OP_DIV) && !m_zero) c = cbit(C_INIT);
      end
      S_EXEC_AS: begin
        c = cbit(C_ALU);
        if (op_q == OP_SUB) c = c | cbit(C_SUB);
      end
      S_MUL_TEST: begin
        // Booth pair {Q0,Q-1}: 01 add M, 10 subtract M, 00/11 no action
        case ({q0, q_1})
          2'b01:   c = cbit(C_ALU);
          2'b10:   c = cbit(C_ALU) | cbit(C_SUB);
          default: c = '0;
        endcase
      end
      S_MUL_SHIFT: c = cbit(C_ASHR);
      S_DIV_SHIFT: c = cbit(C_SHL);
      S_DIV_OP:    c = a_msb ? cbit(C_ALU) : (cbit(C_ALU) | cbit(C_SUB));
      S_DIV_Q:     c = cbit(C_SETQ);
      S_DIV_FIX:   c = a_msb ? cbit(C_ALU) : '0;  // restore a negative remainder
      S_OUT_A:     c = cbit(C_OUTA);
      S_OUT_Q:     c = cbit(C_OUTQ);
      S_DONE:      finish = 1'b1;
      S_ERR: begin
        finish = 1'b1;
        err    = 1'b1;
      end
      default: ;
    endcase
  end

  // Terminal compare must stop the counter before it can pass WIDTH-1
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_b)
    (cnt_val <= CW'(WIDTH - 1)));

endmodule
